// File: rtl/gray_pkg.sv
// Shared types and constants for the Gray-count decode tracker.
package gray_pkg;

    // Width of the running advance accumulator.
    localparam int ADVANCE_WIDTH = 16;

    // Tracker states: waiting for a first sample, following legal steps,
    // or latched on an illegal step until cleared.
    typedef enum logic [1:0] {
        UNPRIMED = 2'd0,
        TRACKING = 2'd1,
        FAULT    = 2'd2
    } state_t;

endpackage

// File: rtl/gray_to_binary.sv
// Purely combinational Gray-to-binary converter.
module gray_to_binary #(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic [COUNTER_WIDTH-1:0] gray,
    output logic [COUNTER_WIDTH-1:0] binary
);

    // Each binary bit is the XOR of all Gray bits at or above its position,
    // which equals b[MSB]=g[MSB], b[i]=b[i+1]^g[i] without a serial chain.
    for (genvar i = 0; i < COUNTER_WIDTH; i++) begin : g_bit
        assign binary[i] = ^(gray >> i);
    end

endmodule

// File: rtl/gray_decode_tracker.sv
// Two-stage Gray count decoder that tracks step size between samples,
// accumulates legal advances and latches a fault on an illegal step.
module gray_decode_tracker
    import gray_pkg::*;
#(
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     Reset_in,
    input  logic                     Clear_in,
    input  logic [COUNTER_WIDTH-1:0] GrayCount_in,
    input  logic                     Valid_in,
    output logic [COUNTER_WIDTH-1:0] BinaryCount_out,
    output logic                     Valid_out,
    output logic [COUNTER_WIDTH-1:0] Step_out,
    output logic                     Error_out,
    output logic                     Fault_out,
    output logic [ADVANCE_WIDTH-1:0] Advance_out
);

    // Stage 1 registers.
    logic [COUNTER_WIDTH-1:0] s1_gray;
    logic                     s1_valid;

    // Stage 2 decode and tracking.
    logic [COUNTER_WIDTH-1:0] s2_binary;
    logic [COUNTER_WIDTH-1:0] prev_value;
    logic [COUNTER_WIDTH-1:0] step_raw;
    logic [COUNTER_WIDTH-1:0] step_next;
    logic                     error_next;
    logic [ADVANCE_WIDTH-1:0] advance_next;
    logic [ADVANCE_WIDTH:0]   advance_sum;

    state_t state, next_state;

    gray_to_binary #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_gray_to_binary (
        .gray   (s1_gray),
        .binary (s2_binary)
    );

    // Stage 1: capture the incoming sample; a clear discards it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (Reset_in) begin
            s1_gray  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_gray  <= GrayCount_in;
            s1_valid <= Valid_in & ~Clear_in;
        end
    end

    // State register; reset wins, clear is folded into next-state logic.
    always_ff @(posedge clk) begin
        if (Reset_in) begin
            state <= UNPRIMED;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, step classification and saturating advance.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        next_state   = state;
        error_next   = 1'b0;
        advance_next = Advance_out;
        step_raw     = s2_binary - prev_value;
        step_next    = step_raw;
        advance_sum  = {1'b0, Advance_out} + (ADVANCE_WIDTH + 1)'(step_raw);

        if (Clear_in) begin
            next_state = UNPRIMED;
        end else if (s1_valid) begin
            unique case (state)
                UNPRIMED: begin
                    // First sample only seeds the previous value.
                    step_next  = '0;
                    next_state = TRACKING;
                end
                TRACKING: begin
                    // Modulo subtraction makes the 2^W-1 -> 0 wrap a step of 1.
                    if (step_raw <= COUNTER_WIDTH'(1)) begin
                        advance_next = advance_sum[ADVANCE_WIDTH] ? '1
                                                                  : advance_sum[ADVANCE_WIDTH-1:0];
                    end else begin
                        error_next = 1'b1;
                        next_state = FAULT;
                    end
                end
                FAULT: begin
                    // Keep decoding; advance stays frozen, no further errors.
                end
                default: begin
                    next_state = UNPRIMED;
                end
            endcase
        end
    end

    // Stage 2 output registers and previous-value tracking.
    always_ff @(posedge clk) begin
        if (Reset_in) begin
            BinaryCount_out <= '0;
            Step_out        <= '0;
            Valid_out       <= 1'b0;
            Error_out       <= 1'b0;
            Advance_out     <= '0;
            prev_value      <= '0;
        end else if (Clear_in) begin
            // Binary and step hold; the in-flight sample is dropped.
            Valid_out   <= 1'b0;
            Error_out   <= 1'b0;
            Advance_out <= '0;
        end else if (s1_valid) begin
            BinaryCount_out <= s2_binary;
            Step_out        <= step_next;
            Valid_out       <= 1'b1;
            Error_out       <= error_next;
            Advance_out     <= advance_next;
            prev_value      <= s2_binary;
        end else begin
            Valid_out <= 1'b0;
            Error_out <= 1'b0;
        end
    end

    // Sticky fault flag follows the registered state.
    assign Fault_out = (state == FAULT);

endmodule

// File: tb/tb_gray_decode_tracker.sv
// Testbench for gray_decode_tracker: directed scenarios plus randomized
// traffic compared against a behavioural model.
module tb_gray_decode_tracker;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         Reset_in;
    logic         Clear_in;
    logic [W-1:0] GrayCount_in;
    logic         Valid_in;
    logic [W-1:0] BinaryCount_out;
    logic         Valid_out;
    logic [W-1:0] Step_out;
    logic         Error_out;
    logic         Fault_out;
    logic [15:0]  Advance_out;

    int total = 0;
    int bad   = 0;

    // Behavioural model state (mode: 0 unprimed, 1 tracking, 2 fault).
    int m_bin, m_step, m_adv, m_mode, m_prev, pend_g;
    bit m_valid, m_err, pend_v;

    always #5 clk = ~clk;

    gray_decode_tracker #(.COUNTER_WIDTH(W)) dut (
        .clk             (clk),
        .Reset_in        (Reset_in),
        .Clear_in        (Clear_in),
        .GrayCount_in    (GrayCount_in),
        .Valid_in        (Valid_in),
        .BinaryCount_out (BinaryCount_out),
        .Valid_out       (Valid_out),
        .Step_out        (Step_out),
        .Error_out       (Error_out),
        .Fault_out       (Fault_out),
        .Advance_out     (Advance_out)
    );

    // Decode by searching for the binary value whose Gray code matches.
    function automatic int g2b(input int g);
        for (int b = 0; b < MOD; b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    // Apply one cycle of inputs, step the clock, and advance the model.
    task automatic drive(input bit v, input int g, input bit clr, input bit rst);
        int b;
        int s;
        Valid_in     = v;
        GrayCount_in = W'(g);
        Clear_in     = clr;
        Reset_in     = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            m_bin = 0; m_step = 0; m_adv = 0; m_mode = 0; m_prev = 0;
            m_valid = 0; m_err = 0; pend_v = 0; pend_g = 0;
        end else if (clr) begin
            m_valid = 0; m_err = 0; m_mode = 0; m_adv = 0; pend_v = 0;
        end else begin
            if (pend_v) begin
                b       = g2b(pend_g);
                s       = (b - m_prev + MOD) % MOD;
                m_valid = 1;
                m_err   = 0;
                m_bin   = b;
                if (m_mode == 0) begin
                    m_step = 0;
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    m_step = s;
                    if (s <= 1) m_adv = (m_adv + s > 65535) ? 65535 : m_adv + s;
                    else begin
                        m_err  = 1;
                        m_mode = 2;
                    end
                end else begin
                    m_step = s;
                end
                m_prev = b;
            end else begin
                m_valid = 0;
                m_err   = 0;
            end
            pend_v = v;
            pend_g = g;
        end
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 5, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b1);
        total++;
        if ({BinaryCount_out, Step_out, Advance_out, Valid_out, Error_out, Fault_out} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {BinaryCount_out, Step_out, Advance_out, Valid_out, Error_out, Fault_out});
        end
        idle();
        total++;
        if (Valid_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_valid: got %b want 0", Valid_out);
        end
    endtask

    task automatic test_count_up();
        int grays[5] = '{0, 1, 3, 2, 6};
        logic [9:0] exp;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(1'b1, grays[i], 1'b0, 1'b0);
            else       idle();
            total++;
            if (i == 0 || i == 6) begin
                if (Valid_out !== 1'b0) begin
                    bad++;
                    $display("FAIL count_up_idle[%0d]: valid got %b want 0", i, Valid_out);
                end
            end else begin
                exp = {1'b1, 4'(i - 1), (i == 1) ? 4'd0 : 4'd1, 1'b0};
                if ({Valid_out, BinaryCount_out, Step_out, Error_out} !== exp) begin
                    bad++;
                    $display("FAIL count_up[%0d]: got %h want %h", i,
                             {Valid_out, BinaryCount_out, Step_out, Error_out}, exp);
                end
            end
        end
        total++;
        if (Advance_out !== 16'd4 || Fault_out !== 1'b0) begin
            bad++;
            $display("FAIL count_up_advance: adv %0d fault %b want 4 0", Advance_out, Fault_out);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 0, 1'b1, 1'b0);
        drive(1'b1, 4'b1001, 1'b0, 1'b0);
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        total++;
        if ({BinaryCount_out, Step_out} !== {4'd15, 4'd1} || Advance_out !== 16'd1) begin
            bad++;
            $display("FAIL wrap_pre: bin %0d step %0d adv %0d want 15 1 1",
                     BinaryCount_out, Step_out, Advance_out);
        end
        idle();
        total++;
        if ({Valid_out, BinaryCount_out, Step_out, Error_out, Fault_out} !== {1'b1, 4'd0, 4'd1, 1'b0, 1'b0}
            || Advance_out !== 16'd2) begin
            bad++;
            $display("FAIL wrap_step: v %b bin %0d step %0d err %b adv %0d want 1 0 1 0 2",
                     Valid_out, BinaryCount_out, Step_out, Error_out, Advance_out);
        end
    endtask

    task automatic test_fault();
        drive(1'b1, 1, 1'b0, 1'b0);
        drive(1'b1, 3, 1'b0, 1'b0);
        drive(1'b1, 4'b0101, 1'b0, 1'b0);
        drive(1'b1, 4'b0100, 1'b0, 1'b0);
        total++;
        if ({Valid_out, BinaryCount_out, Step_out, Error_out, Fault_out} !== {1'b1, 4'd6, 4'd4, 1'b1, 1'b1}
            || Advance_out !== 16'd4) begin
            bad++;
            $display("FAIL fault_entry: v %b bin %0d step %0d err %b flt %b adv %0d want 1 6 4 1 1 4",
                     Valid_out, BinaryCount_out, Step_out, Error_out, Fault_out, Advance_out);
        end
        idle();
        total++;
        if ({Valid_out, BinaryCount_out, Step_out, Error_out, Fault_out} !== {1'b1, 4'd7, 4'd1, 1'b0, 1'b1}
            || Advance_out !== 16'd4) begin
            bad++;
            $display("FAIL fault_legal: v %b bin %0d step %0d err %b flt %b adv %0d want 1 7 1 0 1 4",
                     Valid_out, BinaryCount_out, Step_out, Error_out, Fault_out, Advance_out);
        end
        idle();
        total++;
        if ({Valid_out, Error_out, Fault_out} !== 3'b001) begin
            bad++;
            $display("FAIL fault_sticky: v/err/flt got %b want 001", {Valid_out, Error_out, Fault_out});
        end
    endtask

    task automatic test_clear_from_fault();
        drive(1'b0, 0, 1'b1, 1'b0);
        total++;
        if ({Valid_out, Fault_out, BinaryCount_out, Step_out} !== {1'b0, 1'b0, 4'd7, 4'd1}
            || Advance_out !== 16'd0) begin
            bad++;
            $display("FAIL clear_fault: v %b flt %b bin %0d step %0d adv %0d want 0 0 7 1 0",
                     Valid_out, Fault_out, BinaryCount_out, Step_out, Advance_out);
        end
        drive(1'b1, 6, 1'b0, 1'b0);
        idle();
        total++;
        if ({Valid_out, BinaryCount_out, Step_out, Error_out, Fault_out} !== {1'b1, 4'd4, 4'd0, 1'b0, 1'b0}
            || Advance_out !== 16'd0) begin
            bad++;
            $display("FAIL clear_reprime: v %b bin %0d step %0d err %b flt %b adv %0d want 1 4 0 0 0 0",
                     Valid_out, BinaryCount_out, Step_out, Error_out, Fault_out, Advance_out);
        end
    endtask

    task automatic test_clear_drop();
        drive(1'b1, 7, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            idle();
            total++;
            if (Valid_out !== 1'b0) begin
                bad++;
                $display("FAIL clear_coincident[%0d]: valid got %b want 0", i, Valid_out);
            end
        end
        drive(1'b1, 5, 1'b0, 1'b0);
        drive(1'b0, 0, 1'b1, 1'b0);
        total++;
        if (Valid_out !== 1'b0) begin
            bad++;
            $display("FAIL clear_stage2: valid got %b want 0", Valid_out);
        end
        idle();
        total++;
        if (Valid_out !== 1'b0 || BinaryCount_out !== 4'd4) begin
            bad++;
            $display("FAIL clear_stage2_hold: v %b bin %0d want 0 4", Valid_out, BinaryCount_out);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, b2g(3), 1'b0, 1'b0);
        drive(1'b1, b2g(4), 1'b0, 1'b0);
        drive(1'b1, b2g(5), 1'b0, 1'b0);
        drive(1'b1, b2g(6), 1'b0, 1'b1);
        total++;
        if ({BinaryCount_out, Step_out, Advance_out, Valid_out, Error_out, Fault_out} !== 27'd0) begin
            bad++;
            $display("FAIL midstream_reset: got %h want 0",
                     {BinaryCount_out, Step_out, Advance_out, Valid_out, Error_out, Fault_out});
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            total++;
            if (Valid_out !== 1'b0) begin
                bad++;
                $display("FAIL midstream_quiet[%0d]: valid got %b want 0", i, Valid_out);
            end
        end
        drive(1'b1, b2g(9), 1'b0, 1'b0);
        idle();
        total++;
        if ({Valid_out, BinaryCount_out, Step_out, Error_out, Fault_out} !== {1'b1, 4'd9, 4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midstream_unprimed: v %b bin %0d step %0d err %b flt %b want 1 9 0 0 0",
                     Valid_out, BinaryCount_out, Step_out, Error_out, Fault_out);
        end
    endtask

    task automatic test_random();
        int  cur;
        int  sel;
        bit  v, clr, rst;
        logic [26:0] exp;
        cur = 0;
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 99) < 75);
            clr = ($urandom_range(0, 99) < 4);
            rst = ($urandom_range(0, 199) < 2);
            sel = $urandom_range(0, 9);
            if (sel < 6)      cur = (cur + 1) % MOD;
            else if (sel > 7) cur = $urandom_range(0, MOD - 1);
            drive(v, b2g(cur), clr, rst);
            exp = {m_valid, m_err, (m_mode == 2), W'(m_bin), W'(m_step), 16'(m_adv)};
            total++;
            if ({Valid_out, Error_out, Fault_out, BinaryCount_out, Step_out, Advance_out} !== exp) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h (v,err,flt,bin,step,adv)", n,
                         {Valid_out, Error_out, Fault_out, BinaryCount_out, Step_out, Advance_out}, exp);
            end
        end
    endtask

    initial begin
        Reset_in     = 1'b1;
        Clear_in     = 1'b0;
        Valid_in     = 1'b0;
        GrayCount_in = '0;
        test_reset();
        test_count_up();
        test_wrap();
        test_fault();
        test_clear_from_fault();
        test_clear_drop();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
